// File: rtl/alu_pkg.sv
`default_nettype none
//============================================================================
// Module      : alu_pkg
// Description : Shared widths, opcode encodings and FSM state type for the
//               6-bit ALU response checker.
// Config      : ALU_CHK_CARRY_EN (consumed by alu_response_checker)
// Revision    : 1.0 - initial release
//============================================================================
package alu_pkg;

    localparam int ALU_W = 6;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_NOR = 4'b1100;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_REPORT = 2'd2
    } state_t;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_response_checker_golden.sv
`default_nettype none
//============================================================================
// Module      : alu_golden_model
// Description : Combinational reference model of the 6-bit ALU. Produces the
//               expected result and carry, and flags unsupported opcodes.
// Config      : ALU_CHK_CARRY_EN (carry is always produced here; the top
//               leaves it unobserved when the macro is undefined so synthesis
//               can prune the carry path)
// Revision    : 1.0 - initial release
//============================================================================
module alu_golden_model
    import alu_pkg::*;
(
    input  logic [ALU_W-1:0] a,
    input  logic [ALU_W-1:0] b,
    input  logic             carry_in,
    input  logic [3:0]       op,
    output logic [ALU_W-1:0] exp_result,
    output logic             exp_carry,
    output logic             op_legal
);

    logic [ALU_W:0] sum_add;
    logic [ALU_W:0] sum_sub;

    // 7-bit unsigned sums; SUB ignores carry_in, its carry is the no-borrow flag
    always_comb begin
        sum_add = {1'b0, a} + {1'b0, b} + {{ALU_W{1'b0}}, carry_in};
        sum_sub = {1'b0, a} + {1'b0, ~b} + {{ALU_W{1'b0}}, 1'b1};
    end

    // Opcode decode; anything outside the five supported opcodes is illegal
    always_comb begin
        exp_result = '0;
        exp_carry  = 1'b0;
        op_legal   = 1'b1;
        case (op)
            OP_AND:  exp_result = a & b;
            OP_OR:   exp_result = a | b;
            OP_NOR:  exp_result = ~(a | b);
            OP_ADD:  {exp_carry, exp_result} = sum_add;
            OP_SUB:  {exp_carry, exp_result} = sum_sub;
            default: op_legal = 1'b0;
        endcase
    end

endmodule : alu_golden_model
`default_nettype wire

// File: rtl/alu_response_checker.sv
`default_nettype none
//============================================================================
// Module      : alu_response_checker
// Description : Receiving-end checker for the 6-bit ALU. Recomputes each
//               checked operation, counts pass/fail/illegal with saturating
//               counters, latches the first failure and pulses a summary at
//               the end of each run.
// Config      : ALU_CHK_CARRY_EN - when defined, ADD/SUB also compare
//               carry_out; first-fail exp/act stay result-only.
// Revision    : 1.0 - initial release
//============================================================================
module alu_response_checker
    import alu_pkg::*;
#(
    parameter int CNT_W = 8
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             chk_valid,
    input  logic [ALU_W-1:0] a,
    input  logic [ALU_W-1:0] b,
    input  logic             carry_in,
    input  logic [3:0]       ALU_OP,
    input  logic [ALU_W-1:0] result,
    input  logic             carry_out,
    output logic             mismatch,
    output logic [CNT_W-1:0] pass_count,
    output logic [CNT_W-1:0] fail_count,
    output logic [CNT_W-1:0] illegal_count,
    output logic             first_fail_valid,
    output logic [3:0]       first_fail_op,
    output logic [ALU_W-1:0] first_fail_exp,
    output logic [ALU_W-1:0] first_fail_act,
    output logic             summary_valid,
    output logic             busy
);

    state_t           state;
    state_t           state_next;

    logic [ALU_W-1:0] exp_result;
    logic             exp_carry;
    logic             op_legal;
    logic             check_en;
    logic             run_clear;
    logic             result_bad;
    logic             carry_bad;
    logic             check_fail;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    alu_golden_model u_golden (
        .a          (a),
        .b          (b),
        .carry_in   (carry_in),
        .op         (ALU_OP),
        .exp_result (exp_result),
        .exp_carry  (exp_carry),
        .op_legal   (op_legal)
    );

    assign check_en   = (state == ST_RUN) && chk_valid;
    assign run_clear  = (state == ST_IDLE) && start;
    assign result_bad = (result != exp_result);

`ifdef ALU_CHK_CARRY_EN
    assign carry_bad  = ((ALU_OP == OP_ADD) || (ALU_OP == OP_SUB)) &&
                        (carry_out != exp_carry);
`else
    // Carry is not checked in this build; keep the inputs visibly unused
    logic unused_carry;
    assign unused_carry = carry_out ^ exp_carry;
    assign carry_bad    = 1'b0;
`endif

    assign check_fail    = op_legal && (result_bad || carry_bad);
    assign busy          = (state == ST_RUN);
    assign summary_valid = (state == ST_REPORT);

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state; start beats stop in IDLE, REPORT lasts exactly one cycle
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (start) state_next = ST_RUN;
            ST_RUN:    if (stop)  state_next = ST_REPORT;
            ST_REPORT: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Registered one-cycle mismatch pulse per failed check
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mismatch <= 1'b0;
        end else begin
            mismatch <= check_en && check_fail;
        end
    end

    // Saturating pass/fail/illegal counters, cleared on run entry
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pass_count    <= '0;
            fail_count    <= '0;
            illegal_count <= '0;
        end else if (run_clear) begin
            pass_count    <= '0;
            fail_count    <= '0;
            illegal_count <= '0;
        end else if (check_en) begin
            if (!op_legal) begin
                illegal_count <= sat_inc(illegal_count);
            end else if (check_fail) begin
                fail_count <= sat_inc(fail_count);
            end else begin
                pass_count <= sat_inc(pass_count);
            end
        end
    end

    // First-failure capture; written only while no record is held
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            first_fail_valid <= 1'b0;
            first_fail_op    <= '0;
            first_fail_exp   <= '0;
            first_fail_act   <= '0;
        end else if (run_clear) begin
            first_fail_valid <= 1'b0;
            first_fail_op    <= '0;
            first_fail_exp   <= '0;
            first_fail_act   <= '0;
        end else if (check_en && check_fail && !first_fail_valid) begin
            first_fail_valid <= 1'b1;
            first_fail_op    <= ALU_OP;
            first_fail_exp   <= exp_result;
            first_fail_act   <= result;
        end
    end

endmodule : alu_response_checker
`default_nettype wire

// File: tb/tb_alu_response_checker.sv
`default_nettype none
//============================================================================
// Module      : tb_alu_response_checker
// Description : Directed self-checking bench for alu_response_checker.
// Config      : ALU_CHK_CARRY_EN selects carry-aware expectations
// Revision    : 1.0 - initial release
//============================================================================
module tb_alu_response_checker;

    logic       clk;
    logic       reset;
    logic       start;
    logic       stop;
    logic       chk_valid;
    logic [5:0] a;
    logic [5:0] b;
    logic       carry_in;
    logic [3:0] ALU_OP;
    logic [5:0] result;
    logic       carry_out;
    logic       mismatch;
    logic [7:0] pass_count;
    logic [7:0] fail_count;
    logic [7:0] illegal_count;
    logic       first_fail_valid;
    logic [3:0] first_fail_op;
    logic [5:0] first_fail_exp;
    logic [5:0] first_fail_act;
    logic       summary_valid;
    logic       busy;

    logic [43:0] all_outs;

    int errors = 0;
    int checks = 0;

`ifdef ALU_CHK_CARRY_EN
    localparam logic CARRY_MM = 1'b1;
    localparam int   P_FINAL  = 5;
    localparam int   F_FINAL  = 3;
`else
    localparam logic CARRY_MM = 1'b0;
    localparam int   P_FINAL  = 6;
    localparam int   F_FINAL  = 2;
`endif

    alu_response_checker #(.CNT_W(8)) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .stop             (stop),
        .chk_valid        (chk_valid),
        .a                (a),
        .b                (b),
        .carry_in         (carry_in),
        .ALU_OP           (ALU_OP),
        .result           (result),
        .carry_out        (carry_out),
        .mismatch         (mismatch),
        .pass_count       (pass_count),
        .fail_count       (fail_count),
        .illegal_count    (illegal_count),
        .first_fail_valid (first_fail_valid),
        .first_fail_op    (first_fail_op),
        .first_fail_exp   (first_fail_exp),
        .first_fail_act   (first_fail_act),
        .summary_valid    (summary_valid),
        .busy             (busy)
    );

    assign all_outs = {mismatch, pass_count, fail_count, illegal_count,
                       first_fail_valid, first_fail_op, first_fail_exp,
                       first_fail_act, summary_valid, busy};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change on the falling edge, outputs are read on the falling edge
    task automatic drive(input logic v, input logic [3:0] op, input logic [5:0] aa,
                         input logic [5:0] bb, input logic ci,
                         input logic [5:0] res, input logic co);
        chk_valid = v;
        ALU_OP    = op;
        a         = aa;
        b         = bb;
        carry_in  = ci;
        result    = res;
        carry_out = co;
    endtask

    task automatic idle_inputs();
        start = 1'b0;
        stop  = 1'b0;
        drive(1'b0, 4'b0000, 6'd0, 6'd0, 1'b0, 6'd0, 1'b0);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        @(negedge clk);
        checks++;
        if (all_outs !== 44'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", all_outs);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_busy: got %b expected 0", busy);
        end
    endtask

    task automatic test_add_pass();
        pulse_start();
        checks++;
        if (busy !== 1'b1 || pass_count !== 8'd0) begin
            errors++;
            $display("FAIL start_run: busy %b pass %0d expected 1 / 0", busy, pass_count);
        end
        drive(1'b1, 4'b0010, 6'b100111, 6'b010101, 1'b0, 6'b111100, 1'b0);
        @(negedge clk);
        checks++;
        if (pass_count !== 8'd1 || mismatch !== 1'b0) begin
            errors++;
            $display("FAIL add_pass: pass %0d mm %b expected 1 / 0", pass_count, mismatch);
        end
    endtask

    task automatic test_sub_and();
        // 39 - 21 = 18, no borrow
        drive(1'b1, 4'b0110, 6'b100111, 6'b010101, 1'b0, 6'b010010, 1'b1);
        @(negedge clk);
        checks++;
        if (mismatch !== 1'b0 || pass_count !== 8'd2) begin
            errors++;
            $display("FAIL sub_pass: mm %b pass %0d expected 0 / 2", mismatch, pass_count);
        end
        drive(1'b1, 4'b0000, 6'b100111, 6'b010101, 1'b0, 6'b000000, 1'b0);
        @(negedge clk);
        checks++;
        if (mismatch !== 1'b1 || fail_count !== 8'd1) begin
            errors++;
            $display("FAIL and_fail: mm %b fail %0d expected 1 / 1", mismatch, fail_count);
        end
        checks++;
        if (first_fail_valid !== 1'b1 || first_fail_op !== 4'b0000 ||
            first_fail_exp !== 6'b000101 || first_fail_act !== 6'b000000) begin
            errors++;
            $display("FAIL first_fail_rec: v %b op %b exp %b act %b expected 1 0000 000101 000000",
                     first_fail_valid, first_fail_op, first_fail_exp, first_fail_act);
        end
        drive(1'b1, 4'b0001, 6'b100111, 6'b010101, 1'b0, 6'b110111, 1'b0);
        @(negedge clk);
        checks++;
        if (mismatch !== 1'b0 || pass_count !== 8'd3) begin
            errors++;
            $display("FAIL or_pass_pulse_end: mm %b pass %0d expected 0 / 3", mismatch, pass_count);
        end
        drive(1'b1, 4'b1100, 6'b100111, 6'b010101, 1'b0, 6'b000000, 1'b0);
        @(negedge clk);
        checks++;
        if (fail_count !== 8'd2 || first_fail_op !== 4'b0000 || first_fail_exp !== 6'b000101) begin
            errors++;
            $display("FAIL nor_fail_keep_first: fail %0d op %b exp %b expected 2 0000 000101",
                     fail_count, first_fail_op, first_fail_exp);
        end
        drive(1'b1, 4'b1100, 6'b100111, 6'b010101, 1'b0, 6'b001000, 1'b0);
        @(negedge clk);
        checks++;
        if (mismatch !== 1'b0 || pass_count !== 8'd4) begin
            errors++;
            $display("FAIL nor_pass: mm %b pass %0d expected 0 / 4", mismatch, pass_count);
        end
    endtask

    task automatic test_carry();
        // 63 + 1 = 64: result 0, true carry 1, reported carry 0
        drive(1'b1, 4'b0010, 6'b111111, 6'b000001, 1'b0, 6'b000000, 1'b0);
        @(negedge clk);
        checks++;
        if (mismatch !== CARRY_MM) begin
            errors++;
            $display("FAIL carry_mismatch: got %b expected %b", mismatch, CARRY_MM);
        end
        checks++;
        if (pass_count !== 8'(P_FINAL - 1) || fail_count !== 8'(F_FINAL)) begin
            errors++;
            $display("FAIL carry_counts: pass %0d fail %0d expected %0d / %0d",
                     pass_count, fail_count, P_FINAL - 1, F_FINAL);
        end
    endtask

    task automatic test_illegal();
        drive(1'b1, 4'b0111, 6'b100111, 6'b010101, 1'b0, 6'b101010, 1'b0);
        @(negedge clk);
        checks++;
        if (illegal_count !== 8'd1 || pass_count !== 8'(P_FINAL - 1) ||
            fail_count !== 8'(F_FINAL) || mismatch !== 1'b0) begin
            errors++;
            $display("FAIL illegal_op: ill %0d pass %0d fail %0d mm %b expected 1 %0d %0d 0",
                     illegal_count, pass_count, fail_count, mismatch, P_FINAL - 1, F_FINAL);
        end
    endtask

    task automatic test_stop_with_check();
        stop = 1'b1;
        drive(1'b1, 4'b0010, 6'b100111, 6'b010101, 1'b0, 6'b111100, 1'b0);
        @(negedge clk);
        stop = 1'b0;
        drive(1'b0, 4'b0000, 6'd0, 6'd0, 1'b0, 6'd0, 1'b0);
        checks++;
        if (summary_valid !== 1'b1 || busy !== 1'b0 || pass_count !== 8'(P_FINAL)) begin
            errors++;
            $display("FAIL stop_summary: sv %b busy %b pass %0d expected 1 0 %0d",
                     summary_valid, busy, pass_count, P_FINAL);
        end
        @(negedge clk);
        checks++;
        if (summary_valid !== 1'b0 || pass_count !== 8'(P_FINAL) || fail_count !== 8'(F_FINAL)) begin
            errors++;
            $display("FAIL summary_one_cycle: sv %b pass %0d fail %0d expected 0 %0d %0d",
                     summary_valid, pass_count, fail_count, P_FINAL, F_FINAL);
        end
    endtask

    task automatic test_idle_ignore();
        stop = 1'b1;
        drive(1'b1, 4'b0000, 6'b111111, 6'b111111, 1'b0, 6'b000000, 1'b0);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (pass_count !== 8'(P_FINAL) || fail_count !== 8'(F_FINAL) || illegal_count !== 8'd1 ||
            mismatch !== 1'b0 || busy !== 1'b0 || summary_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_ignore: pass %0d fail %0d ill %0d mm %b busy %b sv %b expected no change",
                     pass_count, fail_count, illegal_count, mismatch, busy, summary_valid);
        end
        idle_inputs();
    endtask

    task automatic test_saturate();
        // start and stop together in IDLE enter RUN
        @(negedge clk);
        start = 1'b1;
        stop  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        checks++;
        if (busy !== 1'b1 || pass_count !== 8'd0 || fail_count !== 8'd0 ||
            illegal_count !== 8'd0 || first_fail_valid !== 1'b0) begin
            errors++;
            $display("FAIL start_clears: busy %b pass %0d fail %0d ill %0d ffv %b expected 1 0 0 0 0",
                     busy, pass_count, fail_count, illegal_count, first_fail_valid);
        end
        drive(1'b1, 4'b0001, 6'b100111, 6'b010101, 1'b0, 6'b110111, 1'b0);
        repeat (300) @(negedge clk);
        checks++;
        if (pass_count !== 8'd255 || fail_count !== 8'd0) begin
            errors++;
            $display("FAIL saturate: pass %0d fail %0d expected 255 / 0", pass_count, fail_count);
        end
        drive(1'b0, 4'b0000, 6'd0, 6'd0, 1'b0, 6'd0, 1'b0);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        checks++;
        if (summary_valid !== 1'b1 || pass_count !== 8'd255) begin
            errors++;
            $display("FAIL sat_summary: sv %b pass %0d expected 1 / 255", summary_valid, pass_count);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_midrun();
        int seen_summary;
        pulse_start();
        drive(1'b1, 4'b0000, 6'b100111, 6'b010101, 1'b0, 6'b000000, 1'b0);
        @(negedge clk);
        drive(1'b0, 4'b0000, 6'd0, 6'd0, 1'b0, 6'd0, 1'b0);
        checks++;
        if (fail_count !== 8'd1 || first_fail_valid !== 1'b1) begin
            errors++;
            $display("FAIL midrun_fail: fail %0d ffv %b expected 1 / 1", fail_count, first_fail_valid);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (all_outs !== 44'd0) begin
            errors++;
            $display("FAIL async_reset: got %h expected 0", all_outs);
        end
        @(negedge clk);
        reset = 1'b0;
        seen_summary = 0;
        repeat (4) begin
            @(negedge clk);
            if (summary_valid !== 1'b0 || busy !== 1'b0) seen_summary++;
        end
        checks++;
        if (seen_summary != 0) begin
            errors++;
            $display("FAIL no_summary_after_reset: got %0d active cycles expected 0", seen_summary);
        end
        pulse_start();
        drive(1'b1, 4'b0010, 6'b100111, 6'b010101, 1'b0, 6'b111100, 1'b0);
        @(negedge clk);
        drive(1'b0, 4'b0000, 6'd0, 6'd0, 1'b0, 6'd0, 1'b0);
        checks++;
        if (pass_count !== 8'd1 || fail_count !== 8'd0 || first_fail_valid !== 1'b0) begin
            errors++;
            $display("FAIL clean_restart: pass %0d fail %0d ffv %b expected 1 0 0",
                     pass_count, fail_count, first_fail_valid);
        end
    endtask

    initial begin
        test_reset();
        test_add_pass();
        test_sub_and();
        test_carry();
        test_illegal();
        test_stop_with_check();
        test_idle_ignore();
        test_saturate();
        test_reset_midrun();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule : tb_alu_response_checker
`default_nettype wire
